// File: rtl/stego_pkg.sv
// rtl/stego_pkg.sv - shared types and constants for the stego message feeder
package stego_pkg;

  typedef enum logic [2:0] {
    MSG_IDLE,
    MSG_LOAD,
    MSG_ARMED,
    MSG_EMBED
  } msg_state_e;

  localparam int BLOCK_DIM = 8;

endpackage

// File: rtl/stego_msg_feeder_if.sv
// rtl/stego_msg_feeder_if.sv - message byte stream interface
interface stego_msg_feeder_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/stego_msg_ram.sv
// rtl/stego_msg_ram.sv - byte-wide message store, one write port, byte-pair async read
module stego_msg_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] raddr_nx;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The second byte wraps; past the message end it is masked by the feeder.
  assign raddr_nx = (raddr == AW'(DEPTH - 1)) ? '0 : raddr + AW'(1);
  assign rdata    = {mem[raddr], mem[raddr_nx]};

endmodule

// File: rtl/stego_msg_feeder.sv
// rtl/stego_msg_feeder.sv - stores a secret message and feeds one bit per channel per block
// Optional STEGO_MSG_LOOP_EN: retain the message and re-embed it at every following frame.
module stego_msg_feeder
  import stego_pkg::*;
#(
  parameter int CHANNELS      = 3,
  parameter int BLOCK_PIXELS  = BLOCK_DIM * BLOCK_DIM,
  parameter int MSG_MAX_BYTES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  stego_msg_feeder_if.slave   s_msg,
  input  logic                pix_valid,
  input  logic                pix_sof,
  output logic [CHANNELS-1:0] msg_bits,
  output logic                msg_active,
  output logic                msg_done,
  output logic                msg_overflow
);

  localparam int AW = (MSG_MAX_BYTES > 1) ? $clog2(MSG_MAX_BYTES) : 1;
  localparam int LW = $clog2(MSG_MAX_BYTES + 1);
  localparam int PW = $clog2(MSG_MAX_BYTES * 8 + CHANNELS + 1);
  localparam int CW = $clog2(BLOCK_PIXELS + 1);
`ifdef STEGO_MSG_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  msg_state_e          state_q, state_d;
  logic [LW-1:0]       len_q, len_d;
  logic [LW-1:0]       wcnt_q, wcnt_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CHANNELS-1:0] win_q, win_rd;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;

  logic                fire, we;
  logic [AW-1:0]       waddr;
  logic [15:0]         rd_pair;
  logic [PW-1:0]       len_bits;
  logic [CHANNELS-1:0] win_raw;

  assign s_msg.tready = (state_q == MSG_IDLE) || (state_q == MSG_LOAD);
  assign fire         = s_msg.tvalid && s_msg.tready;
  assign len_bits     = PW'({len_q, 3'b000});

  stego_msg_ram #(.DEPTH(MSG_MAX_BYTES), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (s_msg.tdata),
    .raddr (AW'(ptr_d >> 3)),
    .rdata (rd_pair)
  );

  // Window is read at the next pointer so new bits land on the edge after a block end.
  always_comb begin
    win_rd  = '0;
    win_raw = CHANNELS'(rd_pair >> (16 - CHANNELS - int'(ptr_d[2:0])));
    for (int c = 0; c < CHANNELS; c++) begin
      win_rd[c] = win_raw[CHANNELS-1-c] && ((ptr_d + PW'(c)) < len_bits);
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    we      = 1'b0;
    waddr   = '0;
    case (state_q)
      MSG_IDLE: begin
        if (fire) begin
          we     = 1'b1;
          ovf_d  = 1'b0;
          wcnt_d = LW'(1);
          if (s_msg.tlast) begin
            state_d = MSG_ARMED;
            len_d   = LW'(1);
          end else begin
            state_d = MSG_LOAD;
          end
        end
      end
      MSG_LOAD: begin
        if (fire) begin
          if (wcnt_q < LW'(MSG_MAX_BYTES)) begin
            we     = 1'b1;
            waddr  = AW'(wcnt_q);
            wcnt_d = wcnt_q + LW'(1);
          end else begin
            ovf_d = 1'b1;
          end
          if (s_msg.tlast) begin
            state_d = MSG_ARMED;
            len_d   = wcnt_d;
          end
        end
      end
      MSG_ARMED: begin
        if (pix_valid && pix_sof) begin
          state_d = MSG_EMBED;
          cnt_d   = CW'(1);
        end
      end
      MSG_EMBED: begin
        if (pix_valid) begin
          if (pix_sof && !LOOP_EN) begin
            cnt_d = CW'(1);
          end else if (cnt_q == CW'(BLOCK_PIXELS - 1)) begin
            cnt_d = '0;
            if ((ptr_q + PW'(CHANNELS)) >= len_bits) begin
              done_d  = 1'b1;
              ptr_d   = '0;
              state_d = LOOP_EN ? MSG_ARMED : MSG_IDLE;
            end else begin
              ptr_d = ptr_q + PW'(CHANNELS);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = MSG_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MSG_IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      win_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      win_q   <= done_d ? '0 : win_rd;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  // Bits are preloaded while armed but only presented once a frame is running.
  assign msg_bits     = (state_q == MSG_EMBED) ? win_q : '0;
  assign msg_active   = (state_q == MSG_EMBED);
  assign msg_done     = done_q;
  assign msg_overflow = ovf_q;

endmodule

// File: tb/tb_stego_msg_feeder.sv
// tb/tb_stego_msg_feeder.sv - randomized self-checking bench for stego_msg_feeder
module tb_stego_msg_feeder;

  localparam int CH   = 3;
  localparam int BP   = 64;
  localparam int MAXB = 16;
`ifdef STEGO_MSG_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pix_valid = 1'b0;
  logic          pix_sof = 1'b0;
  logic [CH-1:0] msg_bits;
  logic          msg_active, msg_done, msg_overflow;

  int total = 0;
  int bad   = 0;

  logic [7:0] ref_mem [MAXB];
  int         ref_len = 0;

  stego_msg_feeder_if m ();

  stego_msg_feeder #(.CHANNELS(CH), .BLOCK_PIXELS(BP), .MSG_MAX_BYTES(MAXB)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_msg        (m),
    .pix_valid    (pix_valid),
    .pix_sof      (pix_sof),
    .msg_bits     (msg_bits),
    .msg_active   (msg_active),
    .msg_done     (msg_done),
    .msg_overflow (msg_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [CH-1:0] exp_blk(input int b);
    logic [CH-1:0] r;
    logic [7:0]    by;
    int            k;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      k = b * CH + c;
      if (k < ref_len * 8) begin
        by   = ref_mem[k / 8];
        r[c] = by[7 - (k % 8)];
      end
    end
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    m.tvalid = 1'b0;
    m.tlast = 1'b0;
    m.tdata = '0;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ref_len = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last, output bit ok);
    m.tdata = b;
    m.tvalid = 1'b1;
    m.tlast = last;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = m.tready;
      @(negedge clk);
    end
    m.tvalid = 1'b0;
    m.tlast = 1'b0;
  endtask

  task automatic load_msg(input logic [7:0] q[$]);
    bit ok;
    for (int i = 0; i < q.size(); i++) begin
      send_byte(q[i], i == q.size() - 1, ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL load_accept: byte %0d not accepted, required accepted", i);
      end
      if (i < MAXB) ref_mem[i] = q[i];
    end
    ref_len = (q.size() < MAXB) ? q.size() : MAXB;
  endtask

  task automatic drive_pixels(input int n, input bit first_sof);
    for (int p = 0; p < n; p++) begin
      pix_valid = 1'b1;
      pix_sof = first_sof && (p == 0);
      @(negedge clk);
    end
    pix_valid = 1'b0;
    pix_sof = 1'b0;
  endtask

  task automatic embed_frame(input string nm, input int maxgap, input bit run);
    int            nblk, npix, blk;
    logic [CH+1:0] exp_v, got;
    nblk = (ref_len * 8 + CH - 1) / CH;
    npix = nblk * BP;
    for (int p = 1; p <= npix; p++) begin
      pix_valid = 1'b1;
      pix_sof = (p == 1);
      @(negedge clk);
      pix_valid = 1'b0;
      pix_sof = 1'b0;
      blk = p / BP;
      if (!run) exp_v = '0;
      else if (p == npix) exp_v = {1'b0, 1'b1, {CH{1'b0}}};
      else exp_v = {1'b1, 1'b0, exp_blk(blk)};
      got = {msg_active, msg_done, msg_bits};
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL %s pix%0d: got {act,done,bits}=%b required %b", nm, p, got, exp_v);
      end
      exp_v[CH] = 1'b0;
      repeat ($urandom_range(0, maxgap)) begin
        @(negedge clk);
        got = {msg_active, msg_done, msg_bits};
        total++;
        if (got !== exp_v) begin
          bad++;
          $display("FAIL %s gap_after_pix%0d: got %b required %b", nm, p, got, exp_v);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({msg_bits, msg_active, msg_done, msg_overflow, m.tready} !== {{CH{1'b0}}, 4'b0001}) begin
      bad++;
      $display("FAIL reset_outputs: got %b required %b",
               {msg_bits, msg_active, msg_done, msg_overflow, m.tready}, {{CH{1'b0}}, 4'b0001});
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] q[$];
    do_reset();
    q = '{8'hA5};
    load_msg(q);
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({m.tready, msg_active, msg_bits, msg_overflow} !== '0) begin
      bad++;
      $display("FAIL armed_quiet: got %b required 0", {m.tready, msg_active, msg_bits, msg_overflow});
    end
    embed_frame("single_a5", 0, 1'b1);
    total++;
    if (m.tready !== !LOOP) begin
      bad++;
      $display("FAIL after_done_ready: got %b required %b", m.tready, !LOOP);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] q[$];
    do_reset();
    q = '{8'hFF, 8'h00};
    load_msg(q);
    embed_frame("gaps_ff00", 3, 1'b1);
  endtask

  task automatic test_no_sof();
    logic [7:0] q[$];
    do_reset();
    q = '{8'($urandom), 8'($urandom)};
    load_msg(q);
    for (int p = 0; p < 30; p++) begin
      pix_valid = 1'b1;
      @(negedge clk);
      pix_valid = 1'b0;
      total++;
      if ({msg_active, msg_bits} !== '0) begin
        bad++;
        $display("FAIL no_sof pix%0d: got %b required 0", p, {msg_active, msg_bits});
      end
    end
    embed_frame("after_no_sof", 1, 1'b1);
  endtask

  task automatic test_overflow();
    logic [7:0] q[$];
    do_reset();
    for (int i = 0; i < MAXB + 5; i++) q.push_back(8'($urandom));
    load_msg(q);
    total++;
    if ({msg_overflow, m.tready} !== 2'b10) begin
      bad++;
      $display("FAIL overflow_armed: got {ovf,ready}=%b required 10", {msg_overflow, m.tready});
    end
    m.tdata = 8'h3C;
    m.tlast = 1'b1;
    m.tvalid = 1'b1;
    embed_frame("overflow_len", 0, 1'b1);
    total++;
    if (m.tready !== !LOOP) begin
      bad++;
      $display("FAIL held_ready: got %b required %b", m.tready, !LOOP);
    end
    @(negedge clk);
    m.tvalid = 1'b0;
    m.tlast = 1'b0;
    total++;
    if ({msg_overflow, m.tready} !== {LOOP, 1'b0}) begin
      bad++;
      $display("FAIL held_consumed: got {ovf,ready}=%b required %b", {msg_overflow, m.tready}, {LOOP, 1'b0});
    end
    if (!LOOP) begin
      ref_mem[0] = 8'h3C;
      ref_len = 1;
      embed_frame("held_byte", 0, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q[$];
    do_reset();
    q = '{8'($urandom), 8'($urandom), 8'($urandom)};
    load_msg(q);
    drive_pixels(BP * 3 + 10, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ref_len = 0;
    total++;
    if ({msg_bits, msg_active, msg_done, msg_overflow, m.tready} !== {{CH{1'b0}}, 4'b0001}) begin
      bad++;
      $display("FAIL reset_mid: got %b required %b",
               {msg_bits, msg_active, msg_done, msg_overflow, m.tready}, {{CH{1'b0}}, 4'b0001});
    end
    q = '{8'h5A};
    load_msg(q);
    embed_frame("reload", 1, 1'b1);
  endtask

  task automatic test_frames();
    logic [7:0] q[$];
    do_reset();
    q = '{8'($urandom)};
    load_msg(q);
    embed_frame("frame1", 0, 1'b1);
    for (int f = 2; f <= 3; f++) begin
      repeat (3) @(negedge clk);
      embed_frame(f == 2 ? "frame2" : "frame3", 0, LOOP);
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    for (int t = 0; t < 3; t++) begin
      do_reset();
      q = {};
      for (int i = 0; i < $urandom_range(1, 5); i++) q.push_back(8'($urandom));
      load_msg(q);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      embed_frame("random", 3, 1'b1);
    end
  endtask

  initial begin
    m.tdata = '0;
    m.tvalid = 1'b0;
    m.tlast = 1'b0;
    test_reset();
    test_single_byte();
    test_gaps();
    test_no_sof();
    test_overflow();
    test_reset_mid();
    test_frames();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
